valu_wb_buffer: RTL and testbench

Writeback buffer on the receiving end of the vector ALU result stream. Fixed-latency ALU units emit `in_valid`/`in_addr`/`in_vec` with no stall capability; this block captures every result in a FIFO and drains it to the vector register file write port over a valid/ready handshake. It also grants issue credits so the issue stage never launches an operation whose result could not be stored.

---
 rtl/valu_wb_buffer.sv | 110 +++++++++++
 tb/tb_valu_wb_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/valu_wb_buffer.sv
// Writeback buffer: captures non-stallable ALU results in a FIFO and drains them to the VRF write port.
// Optional VWB_BYPASS_EN: an empty FIFO forwards in_* straight to wb_* with zero latency.
module valu_wb_buffer #(
  parameter int REQ_DATA_WIDTH = 64,
  parameter int REQ_ADDR_WIDTH = 32,
  parameter int DEPTH          = 8,
  parameter int CNT_WIDTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  output logic                      issue_ok,
  input  logic                      in_valid,
  input  logic [REQ_ADDR_WIDTH-1:0] in_addr,
  input  logic [REQ_DATA_WIDTH-1:0] in_vec,
  output logic                      wb_valid,
  output logic [REQ_ADDR_WIDTH-1:0] wb_addr,
  output logic [REQ_DATA_WIDTH-1:0] wb_data,
  input  logic                      wb_ready,
  output logic [CNT_WIDTH-1:0]      count,
  output logic                      overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH:0]   CREDIT_LIMIT = (CNT_WIDTH + 1)'(DEPTH);

  logic [REQ_ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [REQ_DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_WIDTH-1:0]      inflight;

  logic fifo_valid;
  logic full;
  logic pop_fifo;
  logic bypass_take;
  logic push;
  logic drop;
  logic issue_take;

  assign fifo_valid = (count != '0);
  assign full       = (count == FULL_CNT);

`ifdef VWB_BYPASS_EN
  logic bypass;
  // An empty FIFO lets the arriving result act as the head in the same cycle.
  assign bypass      = !fifo_valid && in_valid;
  assign bypass_take = bypass && wb_ready;
  assign wb_valid    = fifo_valid || bypass;
  assign wb_addr     = fifo_valid ? addr_mem[rd_ptr] : (bypass ? in_addr : '0);
  assign wb_data     = fifo_valid ? data_mem[rd_ptr] : (bypass ? in_vec  : '0);
`else
  assign bypass_take = 1'b0;
  assign wb_valid    = fifo_valid;
  assign wb_addr     = fifo_valid ? addr_mem[rd_ptr] : '0;
  assign wb_data     = fifo_valid ? data_mem[rd_ptr] : '0;
`endif

  assign pop_fifo = fifo_valid && wb_ready;
  // A pop frees the head slot at this edge, so a full FIFO still accepts a result.
  assign push     = in_valid && !bypass_take && (!full || pop_fifo);
  assign drop     = in_valid && full && !pop_fifo;

  assign issue_take = issue_valid && issue_ok;
  assign issue_ok   = ({1'b0, count} + {1'b0, inflight}) < CREDIT_LIMIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_fifo) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop_fifo})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= in_addr;
      data_mem[wr_ptr] <= in_vec;
    end
  end

  // A result with nothing in flight is a protocol error; the counter holds at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else if (issue_take && !in_valid) begin
      inflight <= inflight + CNT_WIDTH'(1);
    end else if (!issue_take && in_valid && (inflight != '0)) begin
      inflight <= inflight - CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_valu_wb_buffer.sv
// Scoreboard bench for valu_wb_buffer: stimulus pushes expected entries, a negedge monitor pops and compares.
// Builds the matching reference behaviour for VWB_BYPASS_EN when that macro is defined.
module tb_valu_wb_buffer;
  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
`ifdef VWB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk, rst, issueValid, issueOk, inValid, wbValid, wbReady, overflow;
  logic [AW-1:0] inAddr, wbAddr;
  logic [DW-1:0] inVec, wbData;
  logic [CW-1:0] count;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        expQ[$];
  int            checks = 0;
  int            errors = 0;
  int            popCount = 0;
  int            mCount = 0;
  int            mInflight = 0;
  bit            mOverflow = 1'b0;
  bit            active = 1'b0;
  logic [AW-1:0] lastAddr = '0;

  valu_wb_buffer #(
    .REQ_DATA_WIDTH(DW), .REQ_ADDR_WIDTH(AW), .DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .issue_valid(issueValid), .issue_ok(issueOk),
    .in_valid(inValid), .in_addr(inAddr), .in_vec(inVec),
    .wb_valid(wbValid), .wb_addr(wbAddr), .wb_data(wbData), .wb_ready(wbReady),
    .count(count), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("count", 64'(count), 64'(mCount));
    checkVal("overflow", 64'(overflow), 64'(mOverflow));
    checkVal("issue_ok", 64'(issueOk), 64'((mCount + mInflight) < DEPTH));
  endtask

  // Drives one cycle starting just after a rising edge, advances the model, checks just after the next edge.
  task automatic applyStimulus(input bit iv, input bit iss, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input bit rdy);
    bit popFifo, push, take, credit;
    issueValid = iss;
    inValid    = iv;
    inAddr     = a;
    inVec      = d;
    wbReady    = rdy;
    credit  = iss && ((mCount + mInflight) < DEPTH);
    popFifo = (mCount > 0) && rdy;
    take    = BYPASS && (mCount == 0) && iv && rdy;
    push    = 1'b0;
    if (iv) begin
      if (take) begin
        expQ.push_back({a, d});
      end else if ((mCount < DEPTH) || popFifo) begin
        expQ.push_back({a, d});
        push = 1'b1;
      end else begin
        mOverflow = 1'b1;
      end
    end
    mCount = mCount + int'(push) - int'(popFifo);
    if (credit && !iv) mInflight++;
    else if (!credit && iv && (mInflight > 0)) mInflight--;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    rst        = 1'b1;
    issueValid = 1'b0;
    inValid    = 1'b0;
    wbReady    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    mCount    = 0;
    mInflight = 0;
    mOverflow = 1'b0;
    active    = 1'b1;
    checkOutput();
    checkVal("reset wb_valid", 64'(wbValid), 64'd0);
    checkVal("reset wb_addr", 64'(wbAddr), 64'd0);
    checkVal("reset wb_data", wbData, 64'd0);
  endtask

  // Monitor: every accepted head must equal the oldest outstanding expected entry.
  always @(negedge clk) begin
    if (active && !rst) begin
      if (wbValid) begin
        if (expQ.size() == 0) begin
          checkVal("spurious wb_valid", 64'(wbValid), 64'd0);
        end else if (wbReady) begin
          entry_t e;
          e = expQ.pop_front();
          checkVal("wb_addr", 64'(wbAddr), 64'(e.addr));
          checkVal("wb_data", wbData, e.data);
          lastAddr = wbAddr;
          popCount++;
        end
      end else begin
        checkVal("idle wb_addr", 64'(wbAddr), 64'd0);
        checkVal("idle wb_data", wbData, 64'd0);
      end
    end
  end

  initial begin
    int base;
    int sent;
    int cyc;
    rst = 1'b1; issueValid = 1'b0; inValid = 1'b0; inAddr = '0; inVec = '0; wbReady = 1'b0;
    doReset();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);

    // Single result, latency depends on the bypass build.
    applyStimulus(1'b0, 1'b1, '0, '0, 1'b0);
    base = popCount;
    applyStimulus(1'b1, 1'b0, AW'('h10), DW'('hDEADBEEF), 1'b1);
`ifdef VWB_BYPASS_EN
    checkVal("bypass same-cycle pop", 64'(popCount - base), 64'd1);
`else
    checkVal("no pop before latency", 64'(popCount - base), 64'd0);
    checkVal("wb_valid after one cycle", 64'(wbValid), 64'd1);
    checkVal("wb_addr after one cycle", 64'(wbAddr), 64'h10);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    checkVal("pop after latency", 64'(popCount - base), 64'd1);
`endif
    checkVal("count back to 0", 64'(count), 64'd0);

    // Credit exhaustion, full push+pop, then overflow.
    doReset();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, '0, '0, 1'b0);
    checkVal("issue_ok after 8 issues", 64'(issueOk), 64'd0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, AW'('h100 + i), {$urandom, $urandom}, 1'b0);
    checkVal("count full", 64'(count), 64'd8);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    checkVal("issue_ok after one pop", 64'(issueOk), 64'd1);
    applyStimulus(1'b1, 1'b0, AW'('h108), {$urandom, $urandom}, 1'b0);
    applyStimulus(1'b1, 1'b0, AW'('h99), {$urandom, $urandom}, 1'b1);
    checkVal("full push+pop count", 64'(count), 64'd8);
    checkVal("full push+pop no overflow", 64'(overflow), 64'd0);
    applyStimulus(1'b1, 1'b0, AW'('hBAD), {$urandom, $urandom}, 1'b0);
    checkVal("overflow set", 64'(overflow), 64'd1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    checkVal("overflow sticky", 64'(overflow), 64'd1);
    checkVal("0x99 is last entry", 64'(lastAddr), 64'h99);
    checkVal("drained after overflow", 64'(expQ.size()), 64'd0);
    doReset();

    // Wrap and order under random ready with credits honoured.
    sent = 0;
    cyc  = 0;
    while ((sent < 20) && (cyc < 2000)) begin
      bit iv;
      iv = (mInflight > 0) && ($urandom_range(0, 1) == 1);
      applyStimulus(iv, 1'($urandom_range(0, 1)), AW'(sent), {$urandom, $urandom},
                    1'($urandom_range(0, 1)));
      if (iv) sent++;
      cyc++;
    end
    checkVal("all 20 results sent", 64'(sent), 64'd20);
    cyc = 0;
    while ((expQ.size() > 0) && (cyc < 100)) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      cyc++;
    end
    checkVal("drained after wrap", 64'(expQ.size()), 64'd0);
    checkVal("last of 0..19", 64'(lastAddr), 64'd19);
    checkVal("no overflow with credits", 64'(overflow), 64'd0);

    // Mid-stream reset discards entries and credits.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, AW'('h200 + i), {$urandom, $urandom}, 1'b0);
    doReset();
    applyStimulus(1'b0, 1'b1, '0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, AW'('h300), {$urandom, $urandom}, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    checkVal("post-reset result drained", 64'(expQ.size()), 64'd0);
    checkVal("post-reset last addr", 64'(lastAddr), 64'h300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
